// File: rtl/transport_send_scheduler.sv
// Transport send scheduler: arbitrates control and audio words towards the
// sender, counts completed packets and requests packet transmission.
module transport_send_scheduler #(
    parameter int unsigned AUDIO_WORDS    = 7,
    parameter int unsigned MAX_CTRL_BURST = 4,
    parameter int unsigned PEND_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_req,
    input  logic [15:0] ctrl_data,
    output logic        ctrl_ack,
    input  logic        audio_req,
    input  logic [15:0] audio_data,
    output logic        audio_ack,
    output logic [1:0]  cmd,
    output logic [15:0] data,
    input  logic        sender_busy,
    input  logic        sender_sending,
    input  logic        tx_enable,
    output logic        send_data,
    output logic        overflow
);

    localparam int unsigned BurstW = $clog2(MAX_CTRL_BURST + 1);
    localparam int unsigned WordW  = (AUDIO_WORDS > 1) ? $clog2(AUDIO_WORDS) : 1;
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_CTRL_BURST);
    localparam logic [WordW-1:0]  WordLast = WordW'(AUDIO_WORDS - 1);
    localparam logic [PEND_W-1:0] PendMax  = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} issue_st_e;
    typedef enum logic [1:0] {SendIdle, SendPulse, SendStart, SendEnd} send_st_e;

    issue_st_e          ist_q, ist_d;
    logic               grant_audio_q, grant_audio_d;
    logic [15:0]        data_q, data_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [BurstW-1:0]  burst_q, burst_d;
    logic [WordW-1:0]   word_q, word_d;
    send_st_e           sst_q, sst_d;
    logic [2:0]         sto_cnt_q, sto_cnt_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic               overflow_q, overflow_d;

    logic grant_ctrl, grant_audio, ctrl_done, audio_done, word_wrap, pend_inc, pend_dec;

    // Issue FSM: grant a requester, present the word for one cycle, track sender progress.
    always_comb begin
        ist_d         = ist_q;
        grant_audio_d = grant_audio_q;
        data_d        = data_q;
        wait_cnt_d    = wait_cnt_q;
        grant_ctrl    = 1'b0;
        grant_audio   = 1'b0;
        ctrl_done     = 1'b0;
        audio_done    = 1'b0;
        cmd           = 2'b00;
        ctrl_ack      = 1'b0;
        audio_ack     = 1'b0;
        case (ist_q)
            StIdle: begin
                if (!sender_busy) begin
                    if (ctrl_req && (!audio_req || burst_q < BurstMax)) begin
                        grant_ctrl    = 1'b1;
                        grant_audio_d = 1'b0;
                        data_d        = ctrl_data;
                        ist_d         = StIssue;
                    end else if (audio_req) begin
                        grant_audio   = 1'b1;
                        grant_audio_d = 1'b1;
                        data_d        = audio_data;
                        ist_d         = StIssue;
                    end
                end
            end
            StIssue: begin
                cmd        = grant_audio_q ? 2'b10 : 2'b01;
                ctrl_ack   = !grant_audio_q;
                audio_ack  = grant_audio_q;
                wait_cnt_d = '0;
                ist_d      = StWaitBusy;
            end
            StWaitBusy: begin
                // Sender never picked the word up: give up without counting it.
                if (sender_busy) begin
                    ist_d = StWaitDone;
                end else if (wait_cnt_q == 2'd3) begin
                    ist_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            StWaitDone: begin
                if (!sender_busy) begin
                    ctrl_done  = !grant_audio_q;
                    audio_done = grant_audio_q;
                    ist_d      = StIdle;
                end
            end
            default: ist_d = StIdle;
        endcase
    end

    // Control burst limiter and audio word counter.
    always_comb begin
        burst_d   = burst_q;
        word_d    = word_q;
        word_wrap = 1'b0;
        // Burst only matters while audio is waiting.
        if (!audio_req || grant_audio) begin
            burst_d = '0;
        end else if (grant_ctrl && burst_q != BurstMax) begin
            burst_d = burst_q + 1'b1;
        end
        if (audio_done) begin
            if (word_q == WordLast) begin
                word_d    = '0;
                word_wrap = 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    // Send FSM: pulse send_data for each pending packet and wait for the sender to finish it.
    always_comb begin
        sst_d     = sst_q;
        sto_cnt_d = sto_cnt_q;
        send_data = 1'b0;
        pend_dec  = 1'b0;
        case (sst_q)
            SendIdle: begin
                if (pending_q != '0 && tx_enable && !sender_sending) begin
                    sst_d = SendPulse;
                end
            end
            SendPulse: begin
                send_data = 1'b1;
                sto_cnt_d = '0;
                sst_d     = SendStart;
            end
            SendStart: begin
                // No packet started: retry later, the packet stays pending.
                if (sender_sending) begin
                    sst_d = SendEnd;
                end else if (sto_cnt_q == 3'd7) begin
                    sst_d = SendIdle;
                end else begin
                    sto_cnt_d = sto_cnt_q + 3'd1;
                end
            end
            SendEnd: begin
                if (!sender_sending) begin
                    pend_dec = 1'b1;
                    sst_d    = SendIdle;
                end
            end
            default: sst_d = SendIdle;
        endcase
    end

    // Pending-packet counter with sticky saturation flag.
    always_comb begin
        pend_inc   = ctrl_done | word_wrap;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (pend_inc && !pend_dec) begin
            if (pending_q == PendMax) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pending_d = pending_q - 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ist_q         <= StIdle;
            grant_audio_q <= 1'b0;
            data_q        <= '0;
            wait_cnt_q    <= '0;
            burst_q       <= '0;
            word_q        <= '0;
            sst_q         <= SendIdle;
            sto_cnt_q     <= '0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
        end else begin
            ist_q         <= ist_d;
            grant_audio_q <= grant_audio_d;
            data_q        <= data_d;
            wait_cnt_q    <= wait_cnt_d;
            burst_q       <= burst_d;
            word_q        <= word_d;
            sst_q         <= sst_d;
            sto_cnt_q     <= sto_cnt_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
        end
    end

    assign data     = data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_transport_send_scheduler.sv
// Bench for transport_send_scheduler: behavioural sender plus per-feature test tasks.
module tb_transport_send_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_req = 1'b0;
    logic [15:0] ctrl_data = '0;
    logic        audio_req = 1'b0;
    logic [15:0] audio_data = '0;
    logic        sender_busy = 1'b0;
    logic        sender_sending = 1'b0;
    logic        tx_enable = 1'b0;
    logic        ctrl_ack, audio_ack, send_data, overflow;
    logic [1:0]  cmd;
    logic [15:0] data;
    logic        ctrl_ack2, audio_ack2, send_data2, overflow2;
    logic [1:0]  cmd2;
    logic [15:0] data2;

    int total = 0;
    int bad = 0;
    logic [17:0] exp_q[$];
    bit busy_en = 1'b1;
    bit send_en = 1'b1;
    int pulses = 0;
    int overlap = 0;

    transport_send_scheduler dut (
        .clk(clk), .reset(reset), .ctrl_req(ctrl_req), .ctrl_data(ctrl_data),
        .ctrl_ack(ctrl_ack), .audio_req(audio_req), .audio_data(audio_data),
        .audio_ack(audio_ack), .cmd(cmd), .data(data), .sender_busy(sender_busy),
        .sender_sending(sender_sending), .tx_enable(tx_enable), .send_data(send_data),
        .overflow(overflow)
    );

    transport_send_scheduler #(.PEND_W(2)) dut2 (
        .clk(clk), .reset(reset), .ctrl_req(ctrl_req), .ctrl_data(ctrl_data),
        .ctrl_ack(ctrl_ack2), .audio_req(audio_req), .audio_data(audio_data),
        .audio_ack(audio_ack2), .cmd(cmd2), .data(data2), .sender_busy(sender_busy),
        .sender_sending(sender_sending), .tx_enable(tx_enable), .send_data(send_data2),
        .overflow(overflow2)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sender: busy for 3 cycles starting the cycle after each issued word.
    initial begin
        forever begin
            step();
            if (cmd !== 2'b00 && busy_en) begin
                step();
                sender_busy = 1'b1;
                repeat (3) step();
                sender_busy = 1'b0;
            end
        end
    end

    // Sender: streams a packet for 3 cycles after each send_data pulse.
    initial begin
        forever begin
            step();
            if (send_data === 1'b1 && send_en) begin
                step();
                sender_sending = 1'b1;
                repeat (3) step();
                sender_sending = 1'b0;
            end
        end
    end

    // Pulse counter, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (send_data === 1'b1) pulses++;
            if (send_data === 1'b1 && sender_sending === 1'b1) overlap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic wait_issue(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cmd !== 2'b00) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ctrl_req = 1'b0;
        audio_req = 1'b0;
        tx_enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!sender_busy && !sender_sending) break;
            step();
        end
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic do_ctrl(input logic [15:0] d, output bit ok);
        ctrl_data = d;
        ctrl_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ctrl_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        ctrl_req = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        bit got;
        logic [17:0] e;
        reset = 1'b0;
        ctrl_data = 16'h1234;
        ctrl_req = 1'b1;
        repeat (3) step();
        total++;
        if ({cmd, data, ctrl_ack, audio_ack, send_data, overflow} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {cmd, data, ctrl_ack, audio_ack, send_data, overflow});
        end
        total++;
        if (dut.pending_q !== 4'd0) begin
            bad++;
            $display("FAIL reset_pending got=%0d exp=0", dut.pending_q);
        end
        exp_q.push_back({2'b01, 16'h1234});
        reset = 1'b1;
        wait_issue(got);
        e = exp_q.pop_front();
        total++;
        if (!got || {cmd, data} !== e) begin
            bad++;
            $display("FAIL held_req_after_reset got=%h exp=%h", {cmd, data}, e);
        end
        ctrl_req = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_ctrl();
        bit got;
        logic [17:0] e;
        int p0;
        do_reset();
        ctrl_data = 16'hA5C3;
        ctrl_req = 1'b1;
        exp_q.push_back({2'b01, 16'hA5C3});
        wait_issue(got);
        e = exp_q.pop_front();
        total++;
        if (!got || {cmd, data} !== e) begin
            bad++;
            $display("FAIL ctrl_issue got=%h exp=%h", {cmd, data}, e);
        end
        total++;
        if ({ctrl_ack, audio_ack} !== 2'b10) begin
            bad++;
            $display("FAIL ctrl_ack got=%b exp=10", {ctrl_ack, audio_ack});
        end
        ctrl_req = 1'b0;
        step();
        total++;
        if ({cmd, data, ctrl_ack} !== {2'b00, 16'hA5C3, 1'b0}) begin
            bad++;
            $display("FAIL ctrl_after_issue got=%h exp=%h", {cmd, data, ctrl_ack},
                     {2'b00, 16'hA5C3, 1'b0});
        end
        repeat (8) step();
        total++;
        if (dut.pending_q !== 4'd1) begin
            bad++;
            $display("FAIL ctrl_pending got=%0d exp=1", dut.pending_q);
        end
        p0 = pulses;
        tx_enable = 1'b1;
        repeat (20) step();
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL ctrl_send_pulses got=%0d exp=1", pulses - p0);
        end
        total++;
        if (dut.pending_q !== 4'd0) begin
            bad++;
            $display("FAIL ctrl_pending_sent got=%0d exp=0", dut.pending_q);
        end
    endtask

    task automatic test_audio();
        bit got;
        logic [17:0] e;
        do_reset();
        audio_data = 16'h1000;
        audio_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({2'b10, 16'(16'h1000 + i)});
            wait_issue(got);
            e = exp_q.pop_front();
            total++;
            if (!got || {cmd, data, ctrl_ack, audio_ack} !== {e, 2'b01}) begin
                bad++;
                $display("FAIL audio_issue_%0d got=%h exp=%h", i,
                         {cmd, data, ctrl_ack, audio_ack}, {e, 2'b01});
            end
            total++;
            if (dut.pending_q !== 4'd0) begin
                bad++;
                $display("FAIL audio_pending_early_%0d got=%0d exp=0", i, dut.pending_q);
            end
            audio_data = 16'(16'h1000 + i + 1);
        end
        audio_req = 1'b0;
        repeat (8) step();
        total++;
        if (dut.pending_q !== 4'd1) begin
            bad++;
            $display("FAIL audio_pending_wrap got=%0d exp=1", dut.pending_q);
        end
        total++;
        if (dut.word_q !== 3'd0) begin
            bad++;
            $display("FAIL audio_word_wrap got=%0d exp=0", dut.word_q);
        end
    endtask

    task automatic test_order();
        bit got;
        logic [17:0] e;
        int nc = 0;
        int na = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) exp_q.push_back({2'b10, 16'(16'hA000 + k / 5)});
            else exp_q.push_back({2'b01, 16'(16'hC000 + k - k / 5)});
        end
        ctrl_data = 16'hC000;
        audio_data = 16'hA000;
        ctrl_req = 1'b1;
        audio_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_issue(got);
            e = exp_q.pop_front();
            total++;
            if (!got || {cmd, data} !== e) begin
                bad++;
                $display("FAIL grant_order_%0d got=%h exp=%h", k, {cmd, data}, e);
            end
            if (ctrl_ack === 1'b1) begin
                nc++;
                ctrl_data = 16'(16'hC000 + nc);
            end
            if (audio_ack === 1'b1) begin
                na++;
                audio_data = 16'(16'hA000 + na);
            end
        end
        ctrl_req = 1'b0;
        audio_req = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_tx_gate();
        bit ok;
        int p0, o0;
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 2; i++) begin
            do_ctrl(16'(16'h2000 + i), ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL gate_ctrl_%0d got=timeout exp=ack", i);
            end
        end
        total++;
        if (dut.pending_q !== 4'd2 || pulses - p0 != 0) begin
            bad++;
            $display("FAIL gate_blocked got=pending %0d pulses %0d exp=pending 2 pulses 0",
                     dut.pending_q, pulses - p0);
        end
        p0 = pulses;
        o0 = overlap;
        tx_enable = 1'b1;
        repeat (40) step();
        total++;
        if (pulses - p0 != 2 || overlap - o0 != 0) begin
            bad++;
            $display("FAIL gate_pulses got=%0d/%0d exp=2/0", pulses - p0, overlap - o0);
        end
        total++;
        if (dut.pending_q !== 4'd0) begin
            bad++;
            $display("FAIL gate_pending got=%0d exp=0", dut.pending_q);
        end
    endtask

    task automatic test_send_timeout();
        bit ok;
        int p0;
        do_reset();
        send_en = 1'b0;
        do_ctrl(16'h3333, ok);
        p0 = pulses;
        tx_enable = 1'b1;
        repeat (25) step();
        tx_enable = 1'b0;
        total++;
        if (!ok || pulses - p0 != 3) begin
            bad++;
            $display("FAIL send_retry_pulses got=%0d exp=3", pulses - p0);
        end
        total++;
        if (dut.pending_q !== 4'd1) begin
            bad++;
            $display("FAIL send_timeout_pending got=%0d exp=1", dut.pending_q);
        end
        send_en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        bit ok, got;
        int n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) do_ctrl(16'(16'h4000 + i), ok);
        total++;
        if (dut.pending_q !== 4'd3) begin
            bad++;
            $display("FAIL mid_pending_setup got=%0d exp=3", dut.pending_q);
        end
        ctrl_data = 16'hBEEF;
        ctrl_req = 1'b1;
        wait_issue(got);
        ctrl_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (!got || {cmd, data, ctrl_ack, audio_ack, send_data, overflow} !== 22'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {cmd, data, ctrl_ack, audio_ack, send_data, overflow});
        end
        total++;
        if (dut.pending_q !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset_pending got=%0d exp=0", dut.pending_q);
        end
        reset = 1'b1;
        repeat (6) step();
        busy_en = 1'b0;
        ctrl_data = 16'h5555;
        ctrl_req = 1'b1;
        wait_issue(got);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cmd !== 2'b00) begin
                n = i;
                break;
            end
        end
        ctrl_req = 1'b0;
        total++;
        if (!got || n != 6) begin
            bad++;
            $display("FAIL busy_timeout_gap got=%0d exp=6", n);
        end
        repeat (8) step();
        total++;
        if (dut.pending_q !== 4'd0) begin
            bad++;
            $display("FAIL busy_timeout_pending got=%0d exp=0", dut.pending_q);
        end
        busy_en = 1'b1;
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) do_ctrl(16'(16'h6000 + i), ok);
        total++;
        if (dut2.pending_q !== 2'd3 || overflow2 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_narrow got=%0d/%b exp=3/1", dut2.pending_q, overflow2);
        end
        total++;
        if (dut.pending_q !== 4'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_wide got=%0d/%b exp=4/0", dut.pending_q, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_audio();
        test_order();
        test_tx_gate();
        test_send_timeout();
        test_reset_midflight();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
